// File: rtl/branch_cond_stage_if.sv
// branch_cond_stage_if: upstream, flag, flush and downstream signals of the branch-condition stage
interface branch_cond_stage_if;
  logic        iEVENT_FLUSH;
  logic        iPREV_INST_VALID;
  logic        oPREV_BUSY;
  logic        iPREV_BRANCH;
  logic [3:0]  iPREV_CC;
  logic [31:0] iPREV_PC;
  logic [31:0] iPREV_TARGET;
  logic [4:0]  iFLAG;
  logic        iFLAG_FWD_VALID;
  logic [4:0]  iFLAG_FWD;
  logic        oNEXT_VALID;
  logic        iNEXT_BUSY;
  logic [31:0] oNEXT_PC;
  logic        oBRANCH_TAKEN;
  logic [31:0] oBRANCH_ADDR;
  logic        oFLUSH_REQ;
  logic        oSHADOW_ACTIVE;
  modport master (
    output iEVENT_FLUSH, iPREV_INST_VALID, iPREV_BRANCH, iPREV_CC, iPREV_PC, iPREV_TARGET,
           iFLAG, iFLAG_FWD_VALID, iFLAG_FWD, iNEXT_BUSY,
    input  oPREV_BUSY, oNEXT_VALID, oNEXT_PC, oBRANCH_TAKEN, oBRANCH_ADDR, oFLUSH_REQ, oSHADOW_ACTIVE
  );
  modport slave (
    input  iEVENT_FLUSH, iPREV_INST_VALID, iPREV_BRANCH, iPREV_CC, iPREV_PC, iPREV_TARGET,
           iFLAG, iFLAG_FWD_VALID, iFLAG_FWD, iNEXT_BUSY,
    output oPREV_BUSY, oNEXT_VALID, oNEXT_PC, oBRANCH_TAKEN, oBRANCH_ADDR, oFLUSH_REQ, oSHADOW_ACTIVE
  );
endinterface

// File: rtl/branch_cond_stage.sv
// branch_cond_stage: evaluates branch condition codes on forwarded flags and drops the wrong-path shadow
module branch_cond_stage #(
  parameter int P_SHADOW = 2
) (
  input logic              iCLOCK,
  input logic              inRESET,
  input logic              iRESET_SYNC,
  branch_cond_stage_if.slave bus
);
  typedef enum logic {RUN, SHADOW} state_t;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d, taken_q, taken_d, flush_q, flush_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d;
  logic [4:0]  f;
  logic        s, o, c, p, z, taken, stall, accept;
  logic [15:0] cc_tab;
  always_comb begin
    f = bus.iFLAG_FWD_VALID ? bus.iFLAG_FWD : bus.iFLAG;
    {s, o, c, p, z} = f;
    cc_tab = {p, z | (s ^ o), ~z & ~(s ^ o), s ^ o, ~(s ^ o), ~c | z, c & ~z,
              ~o, o, ~s, s, ~c, c, ~z, z, 1'b1};
    taken = bus.iPREV_BRANCH & cc_tab[bus.iPREV_CC];
    stall = valid_q & bus.iNEXT_BUSY;
    accept = bus.iPREV_INST_VALID & ~stall;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    valid_d = valid_q;
    taken_d = taken_q;
    pc_d = pc_q;
    addr_d = addr_q;
    flush_d = 1'b0;
    if (bus.iEVENT_FLUSH) begin
      valid_d = 1'b0;
      cnt_d = 3'd0;
      state_d = RUN;
    end else if (!stall) begin
      if (accept && state_q == RUN) begin
        valid_d = 1'b1;
        pc_d = bus.iPREV_PC;
        taken_d = taken;
        addr_d = taken ? bus.iPREV_TARGET : 32'h0;
        flush_d = taken;
        cnt_d = taken ? 3'(P_SHADOW) : cnt_q;
        state_d = taken ? SHADOW : RUN;
      end else if (accept) begin
        valid_d = 1'b0;
        cnt_d = cnt_q - 3'd1;
        state_d = (cnt_q == 3'd1) ? RUN : SHADOW;
      end else begin
        valid_d = 1'b0;
      end
    end
  end
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET || iRESET_SYNC) begin
      state_q <= RUN;
      cnt_q <= 3'd0;
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      flush_q <= 1'b0;
      pc_q <= 32'h0;
      addr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      taken_q <= taken_d;
      flush_q <= flush_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
    end
  end
  assign bus.oPREV_BUSY = stall;
  assign bus.oNEXT_VALID = valid_q;
  assign bus.oNEXT_PC = pc_q;
  assign bus.oBRANCH_TAKEN = taken_q;
  assign bus.oBRANCH_ADDR = addr_q;
  assign bus.oFLUSH_REQ = flush_q;
  assign bus.oSHADOW_ACTIVE = (state_q == SHADOW);
endmodule

// File: tb/tb_branch_cond_stage.sv
// tb_branch_cond_stage: scoreboard bench for the branch-condition stage
module tb_branch_cond_stage;
  localparam int P_SHADOW = 2;
  typedef struct {logic [31:0] pc; logic tk; logic [31:0] addr;} exp_t;
  logic clk = 1'b0, rst_n = 1'b1, rst_sync = 1'b0;
  int n_chk = 0, n_pass = 0, shadow_m = 0;
  exp_t sb[$];
  branch_cond_stage_if bus();
  branch_cond_stage #(.P_SHADOW(P_SHADOW)) dut (.iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rst_sync), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  function automatic logic cond_ref(input logic [3:0] cc, input logic [4:0] fl);
    logic s, o, c, p, z;
    {s, o, c, p, z} = fl;
    case (cc)
      4'd0: return 1'b1;
      4'd1: return z;
      4'd2: return !z;
      4'd3: return c;
      4'd4: return !c;
      4'd5: return s;
      4'd6: return !s;
      4'd7: return o;
      4'd8: return !o;
      4'd9: return c && !z;
      4'd10: return !c || z;
      4'd11: return s == o;
      4'd12: return s != o;
      4'd13: return !z && (s == o);
      4'd14: return z || (s != o);
      default: return p;
    endcase
  endfunction
  task automatic send(input logic br, input logic [3:0] cc, input logic [31:0] pc, input logic [31:0] tgt,
                      input logic [4:0] fl, input logic fv, input logic [4:0] ff);
    logic tk;
    bus.iPREV_INST_VALID = 1'b1;
    bus.iPREV_BRANCH = br;
    bus.iPREV_CC = cc;
    bus.iPREV_PC = pc;
    bus.iPREV_TARGET = tgt;
    bus.iFLAG = fl;
    bus.iFLAG_FWD_VALID = fv;
    bus.iFLAG_FWD = ff;
    tk = br && cond_ref(cc, fv ? ff : fl);
    if (shadow_m > 0) shadow_m--;
    else begin
      sb.push_back('{pc, tk, tk ? tgt : 32'h0});
      if (tk) shadow_m = P_SHADOW;
    end
    @(posedge clk); #1;
    bus.iPREV_INST_VALID = 1'b0;
    bus.iPREV_BRANCH = 1'b0;
    bus.iFLAG_FWD_VALID = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (bus.oNEXT_VALID && !bus.iNEXT_BUSY) begin
      if (sb.size() == 0) check("unexpected_out", bus.oNEXT_PC, 64'hDEAD);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("out_pc", bus.oNEXT_PC, e.pc);
        check("out_taken", bus.oBRANCH_TAKEN, e.tk);
        check("out_addr", bus.oBRANCH_ADDR, e.addr);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [4:0] fls [3];
    fls = '{5'b00000, 5'b11111, 5'b10001};
    bus.iEVENT_FLUSH = 1'b0;
    bus.iPREV_INST_VALID = 1'b0;
    bus.iPREV_BRANCH = 1'b0;
    bus.iPREV_CC = 4'd0;
    bus.iPREV_PC = 32'h0;
    bus.iPREV_TARGET = 32'h0;
    bus.iFLAG = 5'b0;
    bus.iFLAG_FWD_VALID = 1'b0;
    bus.iFLAG_FWD = 5'b0;
    bus.iNEXT_BUSY = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", bus.oNEXT_VALID, 0);
    check("rst_pc", bus.oNEXT_PC, 0);
    check("rst_taken", bus.oBRANCH_TAKEN, 0);
    check("rst_addr", bus.oBRANCH_ADDR, 0);
    check("rst_flush", bus.oFLUSH_REQ, 0);
    check("rst_shadow", bus.oSHADOW_ACTIVE, 0);
    check("rst_busy", bus.oPREV_BUSY, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    for (int fi = 0; fi < 3; fi++)
      for (int cc = 0; cc < 16; cc++) begin
        send(1'b1, 4'(cc), 32'h1000 + 32'(fi * 64 + cc * 4), 32'h8000 + 32'(cc), fls[fi], 1'b0, 5'b0);
        send(1'b0, 4'd0, 32'h2000, 32'h0, 5'b0, 1'b0, 5'b0);
        send(1'b0, 4'd0, 32'h2004, 32'h0, 5'b0, 1'b0, 5'b0);
      end
    send(1'b1, 4'd1, 32'h3000, 32'h3100, 5'b00000, 1'b1, 5'b00001);
    check("fwd_taken", bus.oBRANCH_TAKEN, 1);
    send(1'b0, 4'd0, 32'h3004, 32'h0, 5'b0, 1'b0, 5'b0);
    send(1'b0, 4'd0, 32'h3008, 32'h0, 5'b0, 1'b0, 5'b0);
    send(1'b1, 4'd1, 32'h3010, 32'h3100, 5'b00000, 1'b0, 5'b00001);
    check("nofwd_taken", bus.oBRANCH_TAKEN, 0);
    send(1'b1, 4'd0, 32'h100, 32'h200, 5'b0, 1'b0, 5'b0);
    check("sh_valid", bus.oNEXT_VALID, 1);
    check("sh_flush1", bus.oFLUSH_REQ, 1);
    check("sh_addr", bus.oBRANCH_ADDR, 32'h200);
    check("sh_active1", bus.oSHADOW_ACTIVE, 1);
    send(1'b0, 4'd0, 32'h104, 32'h0, 5'b0, 1'b0, 5'b0);
    check("sh_flush2", bus.oFLUSH_REQ, 0);
    check("sh_drop1", bus.oNEXT_VALID, 0);
    check("sh_active2", bus.oSHADOW_ACTIVE, 1);
    send(1'b1, 4'd0, 32'h108, 32'h900, 5'b0, 1'b0, 5'b0);
    check("sh_drop2", bus.oNEXT_VALID, 0);
    check("sh_active3", bus.oSHADOW_ACTIVE, 0);
    send(1'b0, 4'd0, 32'h10C, 32'h0, 5'b0, 1'b0, 5'b0);
    check("sh_emit", bus.oNEXT_VALID, 1);
    check("sh_emit_pc", bus.oNEXT_PC, 32'h10C);
    idle(1);
    bus.iNEXT_BUSY = 1'b1;
    send(1'b1, 4'd0, 32'h400, 32'h480, 5'b0, 1'b0, 5'b0);
    for (int k = 0; k < 3; k++) begin
      check("st_valid", bus.oNEXT_VALID, 1);
      check("st_pc", bus.oNEXT_PC, 32'h400);
      check("st_addr", bus.oBRANCH_ADDR, 32'h480);
      check("st_busy", bus.oPREV_BUSY, 1);
      check("st_flush", bus.oFLUSH_REQ, k == 0);
      if (k < 2) idle(1);
    end
    bus.iNEXT_BUSY = 1'b0;
    idle(1);
    send(1'b0, 4'd0, 32'h404, 32'h0, 5'b0, 1'b0, 5'b0);
    send(1'b0, 4'd0, 32'h408, 32'h0, 5'b0, 1'b0, 5'b0);
    send(1'b0, 4'd0, 32'h40C, 32'h0, 5'b0, 1'b0, 5'b0);
    send(1'b1, 4'd0, 32'h300, 32'h400, 5'b0, 1'b0, 5'b0);
    bus.iPREV_INST_VALID = 1'b1;
    bus.iPREV_PC = 32'h304;
    bus.iEVENT_FLUSH = 1'b1;
    idle(1);
    bus.iPREV_INST_VALID = 1'b0;
    bus.iEVENT_FLUSH = 1'b0;
    shadow_m = 0;
    check("fl_valid", bus.oNEXT_VALID, 0);
    check("fl_shadow", bus.oSHADOW_ACTIVE, 0);
    check("fl_flush", bus.oFLUSH_REQ, 0);
    send(1'b0, 4'd0, 32'h308, 32'h0, 5'b0, 1'b0, 5'b0);
    check("fl_emit", bus.oNEXT_VALID, 1);
    check("fl_emit_pc", bus.oNEXT_PC, 32'h308);
    send(1'b1, 4'd0, 32'h500, 32'h580, 5'b0, 1'b0, 5'b0);
    rst_sync = 1'b1;
    idle(1);
    rst_sync = 1'b0;
    shadow_m = 0;
    check("srst_valid", bus.oNEXT_VALID, 0);
    check("srst_shadow", bus.oSHADOW_ACTIVE, 0);
    check("srst_addr", bus.oBRANCH_ADDR, 0);
    check("srst_pc", bus.oNEXT_PC, 0);
    idle(1);
    bus.iNEXT_BUSY = 1'b1;
    send(1'b1, 4'd0, 32'h600, 32'h680, 5'b0, 1'b0, 5'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", bus.oNEXT_VALID, 0);
    check("arst_pc", bus.oNEXT_PC, 0);
    check("arst_taken", bus.oBRANCH_TAKEN, 0);
    check("arst_addr", bus.oBRANCH_ADDR, 0);
    check("arst_flush", bus.oFLUSH_REQ, 0);
    check("arst_shadow", bus.oSHADOW_ACTIVE, 0);
    sb.delete();
    shadow_m = 0;
    idle(1);
    rst_n = 1'b1;
    bus.iNEXT_BUSY = 1'b0;
    send(1'b0, 4'd0, 32'h700, 32'h0, 5'b0, 1'b0, 5'b0);
    check("arst_emit", bus.oNEXT_VALID, 1);
    check("arst_emit_pc", bus.oNEXT_PC, 32'h700);
    idle(3);
    check("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
